// File: rtl/pc_sequencer_pkg.sv
// Shared CPU definitions for the fetch-stage PC sequencer: state encoding,
// trap cause codes and instruction size.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    PS_BOOT = 2'b00,
    PS_RUN  = 2'b01,
    PS_HALT = 2'b10,
    PS_TRAP = 2'b11
  } pc_state_e;

  typedef enum logic [1:0] {
    TC_NONE   = 2'b00,
    TC_JUMP   = 2'b01,
    TC_BRANCH = 2'b10
  } trap_cause_e;

  localparam logic [31:0] INSN_SIZE   = 32'd4;
  localparam int unsigned BOOT_CNT_W  = 8;

  // A target is misaligned when either low address bit is set.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/pc_sequencer_boot_timer.sv
// Boot settle counter: counts enabled cycles and flags the last one.
module boot_timer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned WAIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  logic [BOOT_CNT_W-1:0] cnt_q;
  logic [BOOT_CNT_W-1:0] cnt_d;

  // Counter next value: clear has priority over enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {BOOT_CNT_W{1'b0}};
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {BOOT_CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = en_i && (cnt_q == 8'(WAIT - 1));

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: boots the PC register, then picks each cycle
// between increment, jump, branch, stall, halt and trap-vector redirect.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
  parameter int unsigned BOOT_WAIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        boot_req_i,
  input  logic [31:0] boot_addr_i,
  input  logic [31:0] pc_data_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        halt_i,
  output logic        preset_o,
  output logic [31:0] start_addr_o,
  output logic [31:0] pc_next_o,
  output logic        fetch_valid_o,
  output logic        halted_o,
  output logic        trap_o,
  output logic [31:0] trap_pc_o,
  output logic [1:0]  trap_cause_o
);

  pc_state_e   state_q, state_d;
  trap_cause_e cause_q, cause_d;
  logic [31:0] start_addr_q, start_addr_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic        boot_done_s;
  logic        timer_clr_s;
  logic        jump_mis_s;
  logic        branch_mis_s;

  assign jump_mis_s   = is_misaligned(jump_target_i[1:0]);
  assign branch_mis_s = is_misaligned(branch_target_i[1:0]);

  // The counter only runs in BOOT and restarts on every re-boot request.
  assign timer_clr_s = boot_req_i || (state_q != PS_BOOT) || boot_done_s;

  boot_timer #(
    .WAIT (BOOT_WAIT)
  ) u_boot_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (timer_clr_s),
    .en_i   (state_q == PS_BOOT),
    .done_o (boot_done_s)
  );

  // State and latched-address registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= PS_BOOT;
      start_addr_q <= RESET_VEC;
      trap_pc_q    <= 32'h0000_0000;
      cause_q      <= TC_NONE;
    end else begin
      state_q      <= state_d;
      start_addr_q <= start_addr_d;
      trap_pc_q    <= trap_pc_d;
      cause_q      <= cause_d;
    end
  end

  // Next state; a re-boot request overrides everything else.
  always_comb begin
    state_d      = state_q;
    start_addr_d = start_addr_q;
    trap_pc_d    = trap_pc_q;
    cause_d      = cause_q;
    if (boot_req_i) begin
      state_d      = PS_BOOT;
      start_addr_d = boot_addr_i;
    end else begin
      case (state_q)
        PS_BOOT: begin
          if (boot_done_s) begin
            state_d = PS_RUN;
          end else begin
            state_d = PS_BOOT;
          end
        end
        PS_RUN: begin
          if (halt_i) begin
            state_d = PS_HALT;
          end else if (jump_i && jump_mis_s) begin
            state_d   = PS_TRAP;
            trap_pc_d = pc_data_i;
            cause_d   = TC_JUMP;
          end else if (!jump_i && branch_taken_i && branch_mis_s) begin
            state_d   = PS_TRAP;
            trap_pc_d = pc_data_i;
            cause_d   = TC_BRANCH;
          end else begin
            state_d = PS_RUN;
          end
        end
        PS_HALT: state_d = PS_HALT;
        PS_TRAP: state_d = PS_RUN;
        default: state_d = PS_BOOT;
      endcase
    end
  end

  // Combinational PC-register controls; trap detect cycles hold the PC.
  always_comb begin
    preset_o      = 1'b0;
    pc_next_o     = pc_data_i;
    fetch_valid_o = 1'b0;
    halted_o      = 1'b0;
    trap_o        = 1'b0;
    case (state_q)
      PS_BOOT: begin
        preset_o  = 1'b1;
        pc_next_o = start_addr_q;
      end
      PS_RUN: begin
        fetch_valid_o = !stall_i && !halt_i;
        if (halt_i) begin
          pc_next_o = pc_data_i;
        end else if (jump_i) begin
          pc_next_o = jump_mis_s ? pc_data_i : jump_target_i;
        end else if (branch_taken_i) begin
          pc_next_o = branch_mis_s ? pc_data_i : branch_target_i;
        end else if (stall_i) begin
          pc_next_o = pc_data_i;
        end else begin
          pc_next_o = pc_data_i + INSN_SIZE;
        end
      end
      PS_HALT: begin
        halted_o  = 1'b1;
        pc_next_o = pc_data_i;
      end
      PS_TRAP: begin
        trap_o    = 1'b1;
        pc_next_o = TRAP_VEC;
      end
      default: begin
        preset_o  = 1'b1;
        pc_next_o = start_addr_q;
      end
    endcase
  end

  assign start_addr_o = start_addr_q;
  assign trap_pc_o    = trap_pc_q;
  assign trap_cause_o = cause_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with BOOT_WAIT=4.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot_req;
  logic [31:0] boot_addr;
  logic [31:0] pc_data;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        halt;
  logic        preset;
  logic [31:0] start_addr;
  logic [31:0] pc_next;
  logic        fetch_valid;
  logic        halted;
  logic        trap;
  logic [31:0] trap_pc;
  logic [1:0]  trap_cause;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer #(
    .RESET_VEC (32'h0000_0000),
    .TRAP_VEC  (32'h0000_0100),
    .BOOT_WAIT (4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .boot_req_i      (boot_req),
    .boot_addr_i     (boot_addr),
    .pc_data_i       (pc_data),
    .stall_i         (stall),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .halt_i          (halt),
    .preset_o        (preset),
    .start_addr_o    (start_addr),
    .pc_next_o       (pc_next),
    .fetch_valid_o   (fetch_valid),
    .halted_o        (halted),
    .trap_o          (trap),
    .trap_pc_o       (trap_pc),
    .trap_cause_o    (trap_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_boot(input string tag, input logic [31:0] addr);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk({tag, "_preset"}, {31'd0, preset}, 32'd1);
      chk({tag, "_fv"}, {31'd0, fetch_valid}, 32'd0);
      chk({tag, "_start"}, start_addr, addr);
      chk({tag, "_pcnext"}, pc_next, addr);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; boot_req = 1'b0; boot_addr = 32'h0; pc_data = 32'h0;
    stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    jump = 1'b0; jump_target = 32'h0; halt = 1'b0;

    tick();
    tick();
    settle();
    chk("rst_preset", {31'd0, preset}, 32'd1);
    chk("rst_start", start_addr, 32'h0);
    chk("rst_pcnext", pc_next, 32'h0);
    chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_trap", {31'd0, trap}, 32'd0);
    chk("rst_trappc", trap_pc, 32'h0);
    chk("rst_cause", {30'd0, trap_cause}, 32'd0);
    rst = 1'b0;

    // Four boot cycles, then sequential fetch.
    check_boot("boot0", 32'h0);
    for (int i = 0; i < 3; i++) begin
      pc_data = 32'(i * 4);
      settle();
      chk("seq_fv", {31'd0, fetch_valid}, 32'd1);
      chk("seq_preset", {31'd0, preset}, 32'd0);
      chk("seq_pcnext", pc_next, 32'(i * 4 + 4));
      tick();
    end

    // Jump beats a simultaneous branch and stall.
    pc_data = 32'h8; jump = 1'b1; jump_target = 32'h200;
    branch_taken = 1'b1; branch_target = 32'h300; stall = 1'b1;
    settle();
    chk("jump_pcnext", pc_next, 32'h200);
    chk("jump_fv", {31'd0, fetch_valid}, 32'd0);
    tick();
    jump = 1'b0; stall = 1'b0;

    // Misaligned branch: hold, trap cycle, then RUN at the trap vector.
    pc_data = 32'h40; branch_taken = 1'b1; branch_target = 32'h102;
    settle();
    chk("br_hold_pcnext", pc_next, 32'h40);
    chk("br_hold_trap", {31'd0, trap}, 32'd0);
    tick();
    branch_taken = 1'b0;
    settle();
    chk("br_trap", {31'd0, trap}, 32'd1);
    chk("br_trap_pcnext", pc_next, 32'h100);
    chk("br_trap_pc", trap_pc, 32'h40);
    chk("br_trap_cause", {30'd0, trap_cause}, 32'd2);
    chk("br_trap_fv", {31'd0, fetch_valid}, 32'd0);
    tick();
    pc_data = 32'h100;
    settle();
    chk("br_run_trap", {31'd0, trap}, 32'd0);
    chk("br_run_fv", {31'd0, fetch_valid}, 32'd1);
    chk("br_run_pcnext", pc_next, 32'h104);
    chk("br_run_trap_pc", trap_pc, 32'h40);
    tick();

    // Misaligned jump records cause 01.
    pc_data = 32'h104; jump = 1'b1; jump_target = 32'h201;
    settle();
    chk("jm_hold_pcnext", pc_next, 32'h104);
    tick();
    jump = 1'b0;
    settle();
    chk("jm_trap", {31'd0, trap}, 32'd1);
    chk("jm_trap_pc", trap_pc, 32'h104);
    chk("jm_trap_cause", {30'd0, trap_cause}, 32'd1);
    tick();

    // Halt holds the PC until a re-boot request.
    pc_data = 32'h80; halt = 1'b1;
    settle();
    chk("halt_req_pcnext", pc_next, 32'h80);
    chk("halt_req_fv", {31'd0, fetch_valid}, 32'd0);
    tick();
    halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      stall = (i == 3);
      jump = (i == 5); jump_target = 32'h400;
      settle();
      chk("halt_halted", {31'd0, halted}, 32'd1);
      chk("halt_pcnext", pc_next, 32'h80);
      chk("halt_fv", {31'd0, fetch_valid}, 32'd0);
      tick();
    end
    stall = 1'b0; jump = 1'b0;
    boot_req = 1'b1; boot_addr = 32'h1000;
    tick();
    boot_req = 1'b0;
    check_boot("reboot", 32'h1000);
    pc_data = 32'h1000;
    settle();
    chk("reboot_fv", {31'd0, fetch_valid}, 32'd1);
    chk("reboot_halted", {31'd0, halted}, 32'd0);
    chk("reboot_pcnext", pc_next, 32'h1004);
    tick();

    // Wrap at the top of the address space, then stall hold.
    pc_data = 32'hFFFF_FFFC;
    settle();
    chk("wrap_pcnext", pc_next, 32'h0);
    tick();
    pc_data = 32'h2000; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall_pcnext", pc_next, 32'h2000);
      chk("stall_fv", {31'd0, fetch_valid}, 32'd0);
      tick();
    end
    stall = 1'b0;

    // boot_req on the 2nd BOOT cycle restarts the full count.
    boot_req = 1'b1; boot_addr = 32'h3000;
    tick();
    boot_req = 1'b0;
    tick();
    boot_req = 1'b1; boot_addr = 32'h4000;
    settle();
    chk("b2_preset", {31'd0, preset}, 32'd1);
    tick();
    boot_req = 1'b0;
    check_boot("b2", 32'h4000);
    pc_data = 32'h4000;
    settle();
    chk("b2_fv", {31'd0, fetch_valid}, 32'd1);
    tick();

    // rst together with boot_req: reset vector wins.
    rst = 1'b1; boot_req = 1'b1; boot_addr = 32'h5000;
    tick();
    rst = 1'b0; boot_req = 1'b0;
    settle();
    chk("rb_trap_pc", trap_pc, 32'h0);
    chk("rb_cause", {30'd0, trap_cause}, 32'd0);
    check_boot("rb", 32'h0);
    pc_data = 32'h0;
    settle();
    chk("rb_fv", {31'd0, fetch_valid}, 32'd1);
    chk("rb_pcnext", pc_next, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
